// File: rtl/stage_probe_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stage_probe_display: probe-word selector with auto-scan, freeze and       |
// | registered hex seven-segment decode.                    Rev 1.0           |
// +--------------------------------------------------------------------------+
module stage_probe_display #(
  parameter int NUM_CH         = 6,
  parameter int DATA_W         = 32,
  parameter int DWELL          = 50_000_000,
  parameter int SEG_ACTIVE_LOW = 1,
  localparam int SEL_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int DIGITS        = DATA_W / 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     mode,
  input  logic                     freeze,
  output logic [7*DIGITS-1:0]      seg,
  output logic [SEL_W-1:0]         cur_ch,
  output logic                     invalid,
  output logic                     frozen
);

  localparam int               CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] c_CH_LAST  = SEL_W'(NUM_CH - 1);
  localparam logic [6:0]       c_SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [CNT_W-1:0]    r_cnt;
  logic [SEL_W-1:0]    r_cur_ch;
  logic [DATA_W-1:0]   r_snap;
  logic                r_snap_vld;
  logic                r_invalid;
  logic                r_frozen;
  logic [7*DIGITS-1:0] r_seg;

  logic [DATA_W-1:0]   w_word;
  logic                w_valid;
  logic                w_cnt_last;
  logic [SEL_W-1:0]    w_next_ch;
  logic [7*DIGITS-1:0] w_seg;

  function automatic logic [6:0] f_glyph(input logic [3:0] i_nib);
    logic [6:0] v;
    case (i_nib)
      4'h0: v = 7'b1000000;  4'h1: v = 7'b1111001;
      4'h2: v = 7'b0100100;  4'h3: v = 7'b0110000;
      4'h4: v = 7'b0011001;  4'h5: v = 7'b0010010;
      4'h6: v = 7'b0000010;  4'h7: v = 7'b1111000;
      4'h8: v = 7'b0000000;  4'h9: v = 7'b0010000;
      4'hA: v = 7'b0001000;  4'hB: v = 7'b0000011;
      4'hC: v = 7'b1000110;  4'hD: v = 7'b0100001;
      4'hE: v = 7'b0000110;  default: v = 7'b0001110;
    endcase
    return v;
  endfunction

  // Out-of-range indices fall through to all ones so every digit reads F.
  always_comb begin
    w_word  = '1;
    w_valid = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_cur_ch == SEL_W'(k)) begin
        w_word  = ch_data[k*DATA_W +: DATA_W];
        w_valid = 1'b1;
      end
    end
  end

  always_comb begin
    w_cnt_last = (r_cnt == c_CNT_LAST);
    w_next_ch  = (r_cur_ch >= c_CH_LAST) ? '0 : r_cur_ch + SEL_W'(1);
  end

  generate
    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      assign w_seg[d*7 +: 7] = (SEG_ACTIVE_LOW != 0) ? f_glyph(r_snap[d*4 +: 4])
                                                     : ~f_glyph(r_snap[d*4 +: 4]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_cur_ch   <= '0;
      r_snap     <= '0;
      r_snap_vld <= 1'b0;
      r_invalid  <= 1'b0;
      r_frozen   <= 1'b0;
      r_seg      <= {DIGITS{c_SEG_OFF}};
    end else begin
      r_frozen <= freeze;
      if (!freeze) begin
        if (mode) begin
          if (w_cnt_last) begin
            r_cnt    <= '0;
            r_cur_ch <= w_next_ch;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end else begin
          r_cnt    <= '0;
          r_cur_ch <= (NUM_CH == 1) ? '0 : sel;
        end
        r_snap     <= w_valid ? w_word : '1;
        r_invalid  <= ~w_valid;
        r_snap_vld <= 1'b1;
      end
      // Display stays blank until the first snapshot after reset has landed.
      r_seg <= r_snap_vld ? w_seg : {DIGITS{c_SEG_OFF}};
    end
  end

  assign seg     = r_seg;
  assign cur_ch  = r_cur_ch;
  assign invalid = r_invalid;
  assign frozen  = r_frozen;

endmodule
`default_nettype wire

// File: tb/tb_stage_probe_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stage_probe_display: scoreboard bench for two viewer configurations.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_stage_probe_display;

  localparam logic [6:0] c_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    int          cyc;
    bit          inst;
    logic [55:0] seg;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sbq[$];
  exp_t        e;

  // Instance 0: 6 channels, active-low segments. Instance 1: 3 channels, active-high.
  logic        reset0, mode0, freeze0;
  logic [2:0]  sel0;
  logic [31:0] w0 [6];
  logic [191:0] ch0;
  logic [55:0] seg0;
  logic [2:0]  cur0;
  logic        inv0, frz0;

  logic        reset1, mode1, freeze1;
  logic [1:0]  sel1;
  logic [31:0] w1 [3];
  logic [95:0] ch1;
  logic [55:0] seg1;
  logic [1:0]  cur1;
  logic        inv1, frz1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int k = 0; k < 6; k++) ch0[k*32 +: 32] = w0[k];
    for (int k = 0; k < 3; k++) ch1[k*32 +: 32] = w1[k];
  end

  stage_probe_display #(.NUM_CH(6), .DATA_W(32), .DWELL(4), .SEG_ACTIVE_LOW(1)) dut0 (
    .clk(clk), .reset(reset0), .ch_data(ch0), .sel(sel0), .mode(mode0),
    .freeze(freeze0), .seg(seg0), .cur_ch(cur0), .invalid(inv0), .frozen(frz0));

  stage_probe_display #(.NUM_CH(3), .DATA_W(32), .DWELL(4), .SEG_ACTIVE_LOW(0)) dut1 (
    .clk(clk), .reset(reset1), .ch_data(ch1), .sel(sel1), .mode(mode1),
    .freeze(freeze1), .seg(seg1), .cur_ch(cur1), .invalid(inv1), .frozen(frz1));

  function automatic logic [55:0] dec(input logic [31:0] w, input bit active_low);
    logic [55:0] s;
    for (int d = 0; d < 8; d++)
      s[d*7 +: 7] = active_low ? c_GLYPH[w[d*4 +: 4]] : ~c_GLYPH[w[d*4 +: 4]];
    return s;
  endfunction

  function automatic void push(input int at, input bit inst, input logic [55:0] s);
    exp_t x;
    x.cyc  = at;
    x.inst = inst;
    x.seg  = s;
    sbq.push_back(x);
  endfunction

  // Scoreboard: compare each expected display word on the cycle it is due.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      n_checks++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL sb_late: entry due cycle %0d seen at cycle %0d", e.cyc, cyc);
      end else if ((e.inst ? seg1 : seg0) !== e.seg) begin
        n_fail++;
        $display("FAIL sb_seg%0d @%0d: got %h expected %h", e.inst, cyc,
                 e.inst ? seg1 : seg0, e.seg);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  task automatic test_reset;
    step(2);
    n_checks++;
    if (seg0 !== {8{7'h7F}}) begin n_fail++; $display("FAIL rst_seg0: got %h expected %h", seg0, {8{7'h7F}}); end
    n_checks++;
    if (seg1 !== 56'h0) begin n_fail++; $display("FAIL rst_seg1: got %h expected 0", seg1); end
    n_checks++;
    if (cur0 !== 3'd0 || inv0 !== 1'b0 || frz0 !== 1'b0) begin
      n_fail++; $display("FAIL rst_regs: got cur=%0d inv=%b frz=%b expected 0 0 0", cur0, inv0, frz0);
    end
    reset0 = 1'b1;
    reset1 = 1'b1;
    push(cyc + 3, 1'b0, dec(32'h0123_4567, 1'b1));
    push(cyc + 3, 1'b1, dec(32'h0, 1'b0));
    step(3);
  endtask

  task automatic test_manual;
    sel0 = 3'd2;
    push(cyc + 3, 1'b0, dec(32'hDEAD_BEEF, 1'b1));
    step(3);
    chk("man_cur", 64'(cur0), 64'd2);
    chk("man_inv", 64'(inv0), 64'd0);
    sel0 = 3'd7;
    push(cyc + 3, 1'b0, {8{7'b0001110}});
    step(3);
    chk("oor_inv", 64'(inv0), 64'd1);
    chk("oor_cur", 64'(cur0), 64'd7);
    sel0 = 3'd1;
    step(3);
    chk("man_back_inv", 64'(inv0), 64'd0);
  endtask

  task automatic test_freeze;
    int f;
    mode0 = 1'b1;
    step(3);
    chk("frz_pre_cur", 64'(cur0), 64'd1);
    freeze0 = 1'b1;
    f = cyc;
    for (int i = 1; i <= 10; i++) push(f + i, 1'b0, dec(32'hCAFE_F00D, 1'b1));
    step(1);
    chk("frz_flag", 64'(frz0), 64'd1);
    w0[1] = 32'h3141_5926;
    for (int i = 0; i < 9; i++) begin
      step(1);
      if (cur0 !== 3'd1) begin
        n_fail++; $display("FAIL frz_hold_cur: got %0d expected 1", cur0);
      end
      n_checks++;
    end
    freeze0 = 1'b0;
    push(f + 12, 1'b0, dec(32'h3141_5926, 1'b1));
    step(1);
    chk("frz_release_cur", 64'(cur0), 64'd2);
    step(1);
  endtask

  task automatic test_mode_switch;
    mode0 = 1'b0;
    sel0  = 3'd2;
    step(2);
    chk("ms_start", 64'(cur0), 64'd2);
    mode0 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step(1);
      chk("ms_dwell", 64'(cur0), 64'd2);
    end
    step(1);
    chk("ms_advance", 64'(cur0), 64'd3);
    mode0 = 1'b0;
    sel0  = 3'd5;
    step(1);
    chk("ms_manual", 64'(cur0), 64'd5);
  endtask

  task automatic test_auto_wrap;
    int c;
    c = cyc;
    mode1 = 1'b1;
    for (int k = 2; k <= 12; k++) push(c + k, 1'b1, dec(w1[((k - 2) / 4) % 3], 1'b0));
    for (int k = 1; k <= 12; k++) begin
      step(1);
      n_checks++;
      if (cur1 !== 2'(((k / 4) % 3))) begin
        n_fail++; $display("FAIL wrap_cur k=%0d: got %0d expected %0d", k, cur1, (k / 4) % 3);
      end
    end
  endtask

  task automatic test_reset_midscan;
    step(5);
    reset1 = 1'b0;
    step(1);
    chk("mid_rst_cur", 64'(cur1), 64'd0);
    chk("mid_rst_seg", 64'(seg1), 64'd0);
    reset1 = 1'b1;
    step(1);
    chk("mid_rel_blank", 64'(seg1), 64'd0);
    step(1);
    chk("mid_rel_seg", 64'(seg1), 64'(dec(w1[0], 1'b0)));
    step(1);
    chk("mid_rel_ch0", 64'(cur1), 64'd0);
    step(1);
    chk("mid_rel_ch1", 64'(cur1), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset0 = 1'b0; mode0 = 1'b0; freeze0 = 1'b0; sel0 = 3'd0;
    reset1 = 1'b0; mode1 = 1'b0; freeze1 = 1'b0; sel1 = 2'd0;
    w0[0] = 32'h0123_4567; w0[1] = 32'hCAFE_F00D; w0[2] = 32'hDEAD_BEEF;
    w0[3] = 32'h89AB_CDEF; w0[4] = 32'h1357_9BDF; w0[5] = 32'h0246_8ACE;
    w1[0] = 32'h0000_0000; w1[1] = 32'hA5A5_5A5A; w1[2] = 32'hFEDC_BA98;
    test_reset();
    test_manual();
    test_freeze();
    test_mode_switch();
    test_auto_wrap();
    test_reset_midscan();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) step(1);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL sb_pending: entry due cycle %0d never checked", e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
